sdpram32_stream_reader: RTL and testbench
=========================================

# sdpram32_stream_reader

Read-side streaming engine for the 32-bit simple dual-port RAM. On a start command it walks a contiguous word range, drives the RAM read port, and absorbs the RAM's fixed 2-cycle read latency. It also detects reads dropped because a write occupied the RAM in the same cycle. Words are presented on a valid/ready stream with a last flag, for DMA-style consumers such as video or audio fetch.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM word-address width; must match the RAM instance.
- LEN_WIDTH, ADDR_WIDTH+1, transfer length width, so a full-memory transfer (2**ADDR_WIDTH words) is expressible.

Ports:
- clk  in  1  single clock for block and RAM.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  LEN_WIDTH  number of words, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer is complete and the last word has been popped.
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- ram_read_enable  out  1  to RAM read_enable.
- ram_write_enable  in  1  tap of the RAM write_enable; a read issued in a cycle where this is high is discarded by the RAM.
- ram_read_data  in  32  from RAM read_data.
- out_data  out  32  stream word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a word transfers when valid and ready are both high.
- out_last  out  1  high with the final word of a transfer.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE to RUN: start=1 and length>0. The block latches base_addr into addr and length into remaining issue and pop counters.
- IDLE to IDLE when start=1 and length=0: done pulses the next cycle, busy stays 0, and no RAM reads occur.
- In RUN, the block issues a read when issue count > 0 and the credit condition holds (outstanding + fifo_count < 4).
  - ram_read_enable=1 and ram_read_addr=addr.
- Issue acceptance: an issue is accepted only if ram_write_enable=0 in the same cycle.
  - On acceptance: addr increments, the issue counter decrements, and a token enters the 2-stage latency shift register.
  - On collision (ram_write_enable=1): nothing is accepted, and the same addr is reissued on the next eligible cycle.
- Address arithmetic is modulo 2**ADDR_WIDTH; addr wraps from all-ones to 0 mid-transfer without a gap.
- A token reaching the end of the shift register captures ram_read_data into a 4-entry FIFO.
- out_data and out_valid are driven from the FIFO head.
- out_last=1 when the head word is the final word (pop counter == 1).
- RUN to DRAIN when the issue counter reaches 0.
- DRAIN to IDLE on the pop of the last word. done pulses in the cycle after that pop, and busy falls in the same cycle as done.
- A start arriving while busy has no effect.
- When not issuing, ram_read_enable=0 and ram_read_addr holds its last value.
- Reset, including mid-transfer, returns to IDLE and clears the FIFO, counters, and latency tokens. In-flight RAM data arriving after reset is ignored.

## Timing
- Reset values: busy=0, done=0, ram_read_enable=0, ram_read_addr=0, out_valid=0, out_last=0, out_data=0.
- start is sampled at edge 0; the first ram_read_enable=1 is in cycle 1.
- Read latency: a read accepted in cycle t has ram_read_data valid in cycle t+2. It is captured at the end of t+2, and out_valid=1 in cycle t+3.
- The credit window of 4 sustains one word per cycle with out_ready held high; there are no bubbles except those caused by write collisions.
- Simultaneous FIFO push and pop in the same cycle leaves the count unchanged.
- The FIFO never overflows, because credit is checked at issue time.
- out_data and out_last are stable while out_valid=1 and out_ready=0.

## Test plan
- base_addr=0x010, length=4, out_ready=1, no writes: reads of 0x010–0x013 in cycles 1–4; out_valid in cycles 4–7 with the RAM contents in order; out_last in cycle 7; done in cycle 8.
- Same transfer with ram_write_enable=1 in cycle 2: address 0x011 is reissued in cycle 3; the stream contents are still exactly 4 correct words in order; done is delayed by 1 cycle.
- base_addr=0x3FE, length=4, ADDR_WIDTH=10: read addresses are 0x3FE, 0x3FF, 0x000, 0x001.
- length=16 with out_ready low for 10 cycles mid-stream: at most 4 reads are outstanding or buffered, no word is lost or duplicated, and out_data is held stable while stalled.
- length=0: done pulses 1 cycle after start, with busy=0 and no ram_read_enable.
- Reset asserted in the middle of a length=8 transfer, then a new start with length=2: only 2 words stream out, and none are stale.

Source files
------------

// File: rtl/sdpram32_stream_reader_if.sv
// sdpram32_stream_reader_if
//   Output word stream of the RAM stream reader: valid/ready handshake with
//   an end-of-transfer flag.
//   Signals:
//     out_data   32-bit stream word (driven by master)
//     out_valid  word present (driven by master)
//     out_last   final word of the transfer (driven by master)
//     out_ready  consumer can accept a word (driven by slave)
//   A word transfers in a cycle where out_valid and out_ready are both high.
interface sdpram32_stream_reader_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sdpram32_stream_reader.sv
// sdpram32_stream_reader
//   Read-side streaming engine for a 32-bit simple dual-port RAM with a fixed
//   2-cycle read latency. A start command walks a contiguous (wrapping) word
//   range, issues RAM reads under a 4-word credit window, re-issues reads that
//   the RAM dropped because a write used it in the same cycle, and presents
//   the words on a valid/ready stream with a last flag.
//   Ports:
//     clk               clock shared with the RAM
//     reset             synchronous, active-high reset
//     start             one-cycle command strobe, ignored while busy
//     base_addr         first word address, sampled with start
//     length            word count, sampled with start (0 = empty transfer)
//     busy              transfer in progress
//     done              one-cycle pulse after the last word has been popped
//     ram_read_addr     RAM read address
//     ram_read_enable   RAM read enable
//     ram_write_enable  tap of the RAM write enable (a read in that cycle is lost)
//     ram_read_data     RAM read data
//     strm              output word stream (master side)
module sdpram32_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [LEN_WIDTH-1:0]       length,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      ram_read_addr,
    output logic                       ram_read_enable,
    input  logic                       ram_write_enable,
    input  logic [31:0]                ram_read_data,
    sdpram32_stream_reader_if.master   strm
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [LEN_WIDTH-1:0]  issue_cnt_q;
    logic [LEN_WIDTH-1:0]  pop_cnt_q;
    logic                  done_q;

    // Latency tokens: bit 0 = read accepted last cycle, bit 1 = data on the
    // RAM output this cycle.
    logic [1:0]            tok_q;

    logic [31:0]           fifo_mem_q [4];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [2:0]            fifo_cnt_q;

    logic [2:0]            credit_used;
    logic                  issue_req;
    logic                  issue_acc;
    logic                  push;
    logic                  pop;
    logic                  head_valid;

    // Every read in flight already owns a FIFO slot, so the FIFO cannot
    // overflow even if the consumer stalls indefinitely.
    assign credit_used = {2'b00, tok_q[0]} + {2'b00, tok_q[1]} + fifo_cnt_q;
    assign issue_req   = (state_q == StRun) && (issue_cnt_q != '0) && (credit_used < 3'd4);
    // The RAM drops a read that shares its cycle with a write; retry later.
    assign issue_acc   = issue_req && !ram_write_enable;
    assign push        = tok_q[1];
    assign head_valid  = (fifo_cnt_q != 3'd0);
    assign pop         = head_valid && strm.out_ready;

    assign ram_read_enable = issue_req;
    // Hold the last driven address while idle rather than showing addr_q,
    // which has already advanced past it.
    assign ram_read_addr   = issue_req ? addr_q : last_addr_q;

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign strm.out_valid = head_valid;
    assign strm.out_data  = head_valid ? fifo_mem_q[rd_ptr_q] : 32'h0;
    assign strm.out_last  = head_valid && (pop_cnt_q == LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_addr_q <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            done_q      <= 1'b0;
            tok_q       <= 2'b00;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            fifo_cnt_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 32'h0;
            end
        end else begin
            done_q <= 1'b0;
            tok_q  <= {tok_q[0], issue_acc};

            if (issue_req) begin
                last_addr_q <= addr_q;
            end
            if (issue_acc) begin
                addr_q      <= addr_q + 1'b1;
                issue_cnt_q <= issue_cnt_q - 1'b1;
            end

            if (push) begin
                fifo_mem_q[wr_ptr_q] <= ram_read_data;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 2'd1;
                pop_cnt_q <= pop_cnt_q - 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: ;
            endcase

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (length != '0) begin
                            state_q     <= StRun;
                            addr_q      <= base_addr;
                            issue_cnt_q <= length;
                            pop_cnt_q   <= length;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue_acc && (issue_cnt_q == LEN_WIDTH'(1))) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && (pop_cnt_q == LEN_WIDTH'(1))) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sdpram32_stream_reader.sv
module tb_sdpram32_stream_reader;
    localparam int AW    = 10;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_read_addr;
    logic          ram_read_enable;
    logic          ram_write_enable;
    logic [31:0]   ram_read_data;

    sdpram32_stream_reader_if strm ();

    always #5 clk = ~clk;

    sdpram32_stream_reader #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .ram_read_addr    (ram_read_addr),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_read_data    (ram_read_data),
        .strm             (strm)
    );

    // RAM model: 2-cycle read latency; a read colliding with a write returns junk.
    // Contents are kept fixed so the expected stream is fully determined.
    logic [31:0] mem [DEPTH];
    logic [31:0] ram_p1;
    always @(posedge clk) begin
        if (ram_read_enable && !ram_write_enable) ram_p1 <= mem[ram_read_addr];
        else                                      ram_p1 <= $urandom;
        ram_read_data <= ram_p1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int t0  = 1000000;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus modes for the write tap and the consumer.
    bit          we_rand  = 0;
    bit          rdy_rand = 0;
    logic [31:0] we_mask  = 32'h0;
    int          stall_lo = -1;
    int          stall_hi = -1;

    initial begin
        int rel;
        ram_write_enable = 1'b0;
        strm.out_ready   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rel = cyc - t0;
            if (we_rand) ram_write_enable = ($urandom_range(0, 3) == 0);
            else         ram_write_enable = (rel >= 0 && rel < 32) ? we_mask[rel[4:0]] : 1'b0;
            if (rdy_rand) strm.out_ready = ($urandom_range(0, 9) < 7);
            else          strm.out_ready = !(rel >= stall_lo && rel < stall_hi);
        end
    end

    // Reference: a transfer of len words from base yields mem[(base+i) mod DEPTH]
    // in order, the last one flagged, with accepted read addresses in the same order.
    logic [32:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            cur_len = 0;
    int            acc_cnt = 0;
    int            pop_cnt = 0;

    int            rd_cyc_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            val_cyc_q[$];
    int            last_cyc_q[$];
    int            done_cyc_q[$];
    int            busy_cyc_q[$];

    bit            prev_stall = 0;
    logic [32:0]   prev_word;
    int            mon_r;
    logic          mon_acc;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_stall = 0;
            acc_cnt    = 0;
            pop_cnt    = 0;
        end else begin
            mon_r   = cyc - t0;
            mon_acc = ram_read_enable && !ram_write_enable;
            if (ram_read_enable) begin
                rd_cyc_q.push_back(mon_r);
                rd_addr_q.push_back(ram_read_addr);
            end
            if (mon_acc) begin
                if (exp_addr_q.size() != 0) check_eq("read_addr", ram_read_addr, exp_addr_q.pop_front());
                else                        check_eq("read_count", acc_cnt + 1, cur_len);
                check_eq("credit_window", (acc_cnt + 1 - pop_cnt) <= 4, 1);
            end
            if (prev_stall)
                check_eq("stall_hold", {strm.out_valid, strm.out_last, strm.out_data},
                         {1'b1, prev_word});
            if (strm.out_valid) val_cyc_q.push_back(mon_r);
            if (strm.out_valid && strm.out_last) last_cyc_q.push_back(mon_r);
            if (strm.out_valid && strm.out_ready) begin
                if (exp_q.size() != 0) check_eq("stream_word", {strm.out_last, strm.out_data},
                                                exp_q.pop_front());
                else                   check_eq("pop_count", pop_cnt + 1, cur_len);
            end
            if (busy) busy_cyc_q.push_back(mon_r);
            if (done) begin
                done_cyc_q.push_back(mon_r);
                check_eq("done_after_last_pop", pop_cnt, cur_len);
                check_eq("busy_low_with_done", busy, 0);
            end
            prev_stall = strm.out_valid && !strm.out_ready;
            prev_word  = {strm.out_last, strm.out_data};
            if (mon_acc) acc_cnt++;
            if (strm.out_valid && strm.out_ready) pop_cnt++;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_addr_q.delete();
        rd_cyc_q.delete();
        rd_addr_q.delete();
        val_cyc_q.delete();
        last_cyc_q.delete();
        done_cyc_q.delete();
        busy_cyc_q.delete();
        for (int i = 0; i < len; i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), mem[a]});
        end
        cur_len   = len;
        acc_cnt   = 0;
        pop_cnt   = 0;
        start     = 1'b1;
        base_addr = b;
        length    = LW'(len);
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_eq({tag, "_done_seen"}, seen, 1);
        repeat (2) @(negedge clk);
        check_eq({tag, "_all_popped"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, ram_read_enable, 0);
        check_eq({tag, "_rd_addr"}, ram_read_addr, 0);
        check_eq({tag, "_valid"}, strm.out_valid, 0);
        check_eq({tag, "_last"}, strm.out_last, 0);
        check_eq({tag, "_data"}, strm.out_data, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");

        // Basic 4-word transfer, no collisions, consumer always ready.
        do_start(10'h010, 4);
        wait_done("t1", 50);
        check_eq("t1_nreads", rd_cyc_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_rd_cyc%0d", i), rd_cyc_q[i], i + 1);
            check_eq($sformatf("t1_rd_addr%0d", i), rd_addr_q[i], 10'h010 + i);
            check_eq($sformatf("t1_val_cyc%0d", i), val_cyc_q[i], i + 4);
        end
        check_eq("t1_nvalid", val_cyc_q.size(), 4);
        check_eq("t1_last_cyc", last_cyc_q[0], 7);
        check_eq("t1_done_cyc", done_cyc_q[0], 8);
        check_eq("t1_busy_cycles", busy_cyc_q.size(), 7);
        check_eq("t1_busy_first", busy_cyc_q[0], 1);

        // Same transfer with a write colliding in cycle 2.
        we_mask = 32'h4;
        do_start(10'h010, 4);
        wait_done("t2", 50);
        we_mask = 32'h0;
        check_eq("t2_nreads", rd_cyc_q.size(), 5);
        begin
            logic [AW-1:0] t2_addr [5];
            int            t2_val  [4];
            t2_addr = '{10'h010, 10'h011, 10'h011, 10'h012, 10'h013};
            t2_val  = '{4, 6, 7, 8};
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("t2_rd_addr%0d", i), rd_addr_q[i], t2_addr[i]);
                check_eq($sformatf("t2_rd_cyc%0d", i), rd_cyc_q[i], i + 1);
            end
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("t2_val_cyc%0d", i), val_cyc_q[i], t2_val[i]);
        end
        check_eq("t2_done_cyc", done_cyc_q[0], 9);

        // Address wrap at the top of memory.
        do_start(10'h3FE, 4);
        wait_done("t3", 50);
        begin
            logic [AW-1:0] t3_addr [4];
            t3_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("t3_rd_addr%0d", i), rd_addr_q[i], t3_addr[i]);
        end

        // Long consumer stall; a start while busy must be ignored.
        stall_lo = 6;
        stall_hi = 16;
        do_start(10'h050, 16);
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 10'h200;
        length    = LW'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4", 200);
        stall_lo = -1;
        stall_hi = -1;
        check_eq("t4_pops", pop_cnt, 16);
        check_eq("t4_reads", acc_cnt, 16);

        // Zero-length command.
        do_start(10'h123, 0);
        wait_done("t5", 10);
        check_eq("t5_done_cyc", done_cyc_q[0], 1);
        check_eq("t5_ndone", done_cyc_q.size(), 1);
        check_eq("t5_no_reads", rd_cyc_q.size(), 0);
        check_eq("t5_no_busy", busy_cyc_q.size(), 0);

        // Reset in the middle of a transfer, then a fresh short transfer.
        do_start(10'h100, 8);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("midreset");
        do_start(10'h180, 2);
        wait_done("t6", 50);
        check_eq("t6_pops", pop_cnt, 2);
        check_eq("t6_nvalid", val_cyc_q.size(), 2);

        // Randomized transfers with random collisions and consumer stalls.
        we_rand  = 1;
        rdy_rand = 1;
        for (int n = 0; n < 12; n++) begin
            do_start(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 40));
            wait_done($sformatf("rnd%0d", n), 2000);
        end
        // Full-memory transfer exercises the top of the length range.
        do_start(AW'($urandom_range(0, DEPTH - 1)), DEPTH);
        wait_done("full", 10000);
        check_eq("full_pops", pop_cnt, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
